// File: rtl/data_memory_if.sv
// Bus between the ALU stage and the data memory / write-back mux.
interface data_memory_if;
    logic        MemToReg;
    logic        MemWrite;
    logic [1:0]  loadStoreWidth;
    logic        loadSign;
    logic [31:0] memAddr;
    logic [31:0] writeData;
    logic [31:0] writeBackData;

    modport master (
        output MemToReg,
        output MemWrite,
        output loadStoreWidth,
        output loadSign,
        output memAddr,
        output writeData,
        input  writeBackData
    );

    modport slave (
        input  MemToReg,
        input  MemWrite,
        input  loadStoreWidth,
        input  loadSign,
        input  memAddr,
        input  writeData,
        output writeBackData
    );
endinterface

// File: rtl/data_memory.sv
// Byte-addressed little-endian data memory with write-back mux.
// Stores on the falling clock edge, loads combinationally with zero/sign
// extension; multi-byte accesses wrap modulo DEPTH and may be unaligned.
module data_memory #(
    parameter int unsigned DEPTH = 128
) (
    input  logic         CLK,
    input  logic         RST,
    data_memory_if.slave bus
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned LANES  = 4;

    logic [7:0]        mem    [DEPTH];
    logic [ADDR_W-1:0] addr   [LANES];
    logic [7:0]        rdByte [LANES];
    logic              isHalf;
    logic              isWord;
    logic [31:0]       loadedData;

    // Width decode; 2'b10 behaves as a word access.
    always_comb begin
        isHalf = (bus.loadStoreWidth == 2'b01);
        isWord = bus.loadStoreWidth[1];
    end

    // Per-lane byte addresses (wrapping) and the bytes currently stored there.
    always_comb begin
        for (int unsigned k = 0; k < LANES; k++) begin
            addr[k]   = bus.memAddr[ADDR_W-1:0] + ADDR_W'(k);
            rdByte[k] = mem[addr[k]];
        end
    end

    // Store on the falling edge; reset clears the array immediately.
    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[ADDR_W'(i)] <= 8'h00;
            end
        end else if (bus.MemWrite) begin
            mem[addr[0]] <= bus.writeData[7:0];
            if (isHalf || isWord) begin
                mem[addr[1]] <= bus.writeData[15:8];
            end
            if (isWord) begin
                mem[addr[2]] <= bus.writeData[23:16];
                mem[addr[3]] <= bus.writeData[31:24];
            end
        end
    end

    // Load extension and write-back selection.
    always_comb begin
        loadedData = {rdByte[3], rdByte[2], rdByte[1], rdByte[0]};
        if (isHalf) begin
            loadedData = {{16{bus.loadSign & rdByte[1][7]}}, rdByte[1], rdByte[0]};
        end else if (!isWord) begin
            loadedData = {{24{bus.loadSign & rdByte[0][7]}}, rdByte[0]};
        end
        bus.writeBackData = bus.MemToReg ? loadedData : bus.memAddr;
    end
endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed cases followed by random
// loads/stores checked against a byte-array reference model.
module tb_data_memory;
    localparam int unsigned DEPTH = 128;

    logic CLK;
    logic RST;
    data_memory_if intf ();

    data_memory #(.DEPTH(DEPTH)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (intf.slave)
    );

    int testCount = 0;
    int failCount = 0;
    byte unsigned refMem [DEPTH];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic int unsigned widthBytes(input logic [1:0] w);
        if (w == 2'b00) return 1;
        if (w == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] refLoad(input logic [31:0] a, input logic [1:0] w, input logic s);
        int unsigned n;
        logic [31:0] v;
        n = widthBytes(w);
        v = 32'h0;
        for (int unsigned k = 0; k < n; k++) begin
            v = v | (32'(refMem[(a + k) % DEPTH]) << (8 * k));
        end
        if (n < 4 && s && v[8 * n - 1]) begin
            v = v | ~((32'h1 << (8 * n)) - 32'h1);
        end
        return v;
    endfunction

    task automatic refStore(input logic [31:0] a, input logic [1:0] w, input logic [31:0] d);
        int unsigned n;
        n = widthBytes(w);
        for (int unsigned k = 0; k < n; k++) begin
            refMem[(a + k) % DEPTH] = 8'((d >> (8 * k)) & 32'hFF);
        end
    endtask

    task automatic refClear();
        for (int unsigned i = 0; i < DEPTH; i++) refMem[i] = 8'h00;
    endtask

    task automatic check(input string tag, input logic [31:0] expected);
        logic [31:0] observed;
        observed = intf.writeBackData;
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic driveLoad(input logic [31:0] a, input logic [1:0] w, input logic s);
        intf.MemWrite       = 1'b0;
        intf.MemToReg       = 1'b1;
        intf.memAddr        = a;
        intf.loadStoreWidth = w;
        intf.loadSign       = s;
        #1;
    endtask

    task automatic doStore(input logic [31:0] a, input logic [1:0] w, input logic [31:0] d);
        intf.MemWrite       = 1'b1;
        intf.MemToReg       = 1'b0;
        intf.memAddr        = a;
        intf.loadStoreWidth = w;
        intf.writeData      = d;
        @(negedge CLK);
        refStore(a, w, d);
        #1;
        intf.MemWrite = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  w;
        logic        s;

        intf.MemToReg       = 1'b0;
        intf.MemWrite       = 1'b0;
        intf.loadStoreWidth = 2'b11;
        intf.loadSign       = 1'b0;
        intf.memAddr        = 32'h0;
        intf.writeData      = 32'h0;
        RST = 1'b0;
        refClear();

        // Reset pulse; output and memory defined during reset.
        #2 RST = 1'b1;
        driveLoad(32'h20, 2'b11, 1'b0);
        check("rst_load_word", 32'h0000_0000);
        intf.MemToReg = 1'b0;
        #1;
        check("rst_passthru", 32'h0000_0020);
        #10 RST = 1'b0;
        driveLoad(32'h20, 2'b11, 1'b0);
        check("post_rst_word", 32'h0000_0000);

        // Byte store and zero/sign extended loads.
        intf.MemWrite = 1'b1; intf.MemToReg = 1'b0; intf.memAddr = 32'h13;
        intf.loadStoreWidth = 2'b00; intf.writeData = 32'hA1;
        #1;
        check("store_passthru", 32'h0000_0013);
        @(negedge CLK);
        refStore(32'h13, 2'b00, 32'hA1);
        #1 intf.MemWrite = 1'b0;
        driveLoad(32'h13, 2'b00, 1'b0);
        check("byte_zext", 32'h0000_00A1);
        driveLoad(32'h13, 2'b00, 1'b1);
        check("byte_sext", 32'hFFFF_FFA1);

        // Unaligned halfword.
        doStore(32'h11, 2'b01, 32'h0000_A1A1);
        driveLoad(32'h11, 2'b01, 1'b1);
        check("half_sext", 32'hFFFF_A1A1);
        driveLoad(32'h11, 2'b01, 1'b0);
        check("half_zext", 32'h0000_A1A1);
        driveLoad(32'h12, 2'b00, 1'b0);
        check("half_byte_hi", 32'h0000_00A1);

        // Unaligned word over the halfword.
        doStore(32'h12, 2'b11, 32'h00A1_A1A1);
        driveLoad(32'h12, 2'b11, 1'b1);
        check("word_load", 32'h00A1_A1A1);
        driveLoad(32'h11, 2'b01, 1'b0);
        check("half_after_word", 32'h0000_A1A1);

        // Wrap at the top of the array and address aliasing.
        doStore(32'(DEPTH - 1), 2'b11, 32'h1122_3344);
        driveLoad(32'h0, 2'b00, 1'b0);
        check("wrap_byte0", 32'h0000_0033);
        driveLoad(32'(DEPTH - 1), 2'b00, 1'b0);
        check("wrap_byte_top", 32'h0000_0044);
        driveLoad(32'h1000_0000 + 32'(DEPTH - 1), 2'b11, 1'b0);
        check("wrap_alias_word", 32'h1122_3344);
        driveLoad(32'(DEPTH - 1), 2'b10, 1'b1);
        check("width10_as_word", 32'h1122_3344);

        // Read-after-write within the same cycle.
        doStore(32'h40, 2'b11, 32'h1234_5678);
        intf.MemWrite = 1'b1; intf.MemToReg = 1'b1; intf.memAddr = 32'h40;
        intf.loadStoreWidth = 2'b00; intf.loadSign = 1'b0; intf.writeData = 32'hFF;
        #1;
        check("raw_before", 32'h0000_0078);
        @(negedge CLK);
        refStore(32'h40, 2'b00, 32'hFF);
        #1;
        check("raw_after", 32'h0000_00FF);
        intf.MemWrite = 1'b0;
        driveLoad(32'h40, 2'b11, 1'b0);
        check("byte_over_word", 32'h1234_56FF);

        // Reset between setup and the falling edge discards the store.
        intf.MemWrite = 1'b1; intf.MemToReg = 1'b1; intf.memAddr = 32'h40;
        intf.loadStoreWidth = 2'b11; intf.writeData = 32'hDEAD_BEEF;
        #1;
        check("pre_rst_old", 32'h1234_56FF);
        RST = 1'b1;
        #1;
        check("mid_rst_cleared", 32'h0000_0000);
        @(negedge CLK);
        #1;
        RST = 1'b0;
        intf.MemWrite = 1'b0;
        refClear();
        driveLoad(32'h40, 2'b11, 1'b0);
        check("rst_drop_write", 32'h0000_0000);
        driveLoad(32'h11, 2'b01, 1'b0);
        check("rst_cleared_other", 32'h0000_0000);

        // Random mix of stores and loads against the reference model.
        for (int it = 0; it < 300; it++) begin
            a = $urandom();
            if ($urandom_range(0, 1) == 0) a = a & 32'h0000_00FF;
            w = 2'($urandom_range(0, 3));
            d = $urandom();
            s = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) begin
                doStore(a, w, d);
            end else begin
                driveLoad(a, w, s);
                check("rand_load", refLoad(a, w, s));
                intf.MemToReg = 1'b0;
                #1;
                check("rand_passthru", a);
            end
        end

        // Sweep the whole array as words to catch any stray writes.
        for (int unsigned i = 0; i < DEPTH; i += 4) begin
            driveLoad(32'(i), 2'b11, 1'b0);
            check("final_sweep", refLoad(32'(i), 2'b11, 1'b0));
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
